// File: rtl/bus_pkg.sv
// Shared definitions for the two-master memory bus arbiter: FSM states,
// master indices, region decode default and the Cpu read/write encodings.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } arb_state_t;

  localparam int NUM_MASTERS = 2;
  localparam int M_CPU       = 0;
  localparam int M_DMA       = 1;

  // addr[15:14] value that maps to ROM; everything else is RAM
  localparam logic [1:0] ROM_TOP = 2'b00;

  localparam logic IO_READ  = 1'b0;
  localparam logic IO_WRITE = 1'b1;

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational winner select for the bus arbiter. Fixed priority (Cpu first)
// by default; with BUS_ARB_RR_EN a tie goes to the master not granted last.
module bus_arb_pick
  import bus_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
`ifdef BUS_ARB_RR_EN
  input  logic                   last_gnt,
`endif
  output logic                   valid,
  output logic                   idx
);

  always_comb begin
    valid = |req;
    idx   = req[M_CPU] ? 1'(M_CPU) : 1'(M_DMA);
`ifdef BUS_ARB_RR_EN
    if (&req) begin
      idx = ~last_gnt;
    end
`endif
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master memory bus arbiter: one transaction at a time, ROM/RAM decode,
// optional read latency. Define BUS_ARB_RR_EN for round-robin arbitration.
module bus_arbiter #(
  parameter int         RD_LATENCY = 0,
  parameter logic [1:0] ROM_TOP    = bus_pkg::ROM_TOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  m_req,
  input  logic [1:0]  m_we,
  input  logic [31:0] m_addr,
  input  logic [15:0] m_wdata,
  output logic [1:0]  m_gnt,
  output logic [1:0]  m_rvalid,
  output logic [7:0]  m_rdata,
  output logic        ro_err,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic        cs_rom,
  output logic        cs_ram,
  input  logic [7:0]  mem_rdata
);
  import bus_pkg::*;

  logic [15:0] addr_arr  [NUM_MASTERS];
  logic [7:0]  wdata_arr [NUM_MASTERS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
      assign addr_arr[gi]  = m_addr[16*gi +: 16];
      assign wdata_arr[gi] = m_wdata[8*gi +: 8];
    end
  endgenerate

  arb_state_t  state_reg;
  logic        win_reg;
  logic        we_reg;
  logic [1:0]  cnt_reg;
  logic        pick_valid;
  logic        pick_idx;
  logic        pick_is_rom;

`ifdef BUS_ARB_RR_EN
  logic        last_reg;
`endif

  bus_arb_pick u_pick (
    .req      (m_req),
`ifdef BUS_ARB_RR_EN
    .last_gnt (last_reg),
`endif
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  assign pick_is_rom = (addr_arr[pick_idx][15:14] == ROM_TOP);

  // Outputs are registered, so the ACCESS-cycle bus values are loaded on the
  // IDLE->ACCESS edge; mem_addr/mem_wdata double as the latched request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      win_reg   <= 1'b0;
      we_reg    <= 1'b0;
      cnt_reg   <= '0;
      m_gnt     <= '0;
      m_rvalid  <= '0;
      m_rdata   <= '0;
      ro_err    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      cs_rom    <= 1'b0;
      cs_ram    <= 1'b0;
`ifdef BUS_ARB_RR_EN
      last_reg  <= 1'b1;
`endif
    end else begin
      m_gnt    <= '0;
      m_rvalid <= '0;
      ro_err   <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            win_reg           <= pick_idx;
            we_reg            <= m_we[pick_idx];
            mem_addr          <= addr_arr[pick_idx];
            mem_wdata         <= wdata_arr[pick_idx];
            m_gnt[pick_idx]   <= 1'b1;
            if (m_we[pick_idx] == IO_WRITE) begin
              // ROM writes are dropped: no strobe, no chip select
              if (pick_is_rom) begin
                ro_err <= 1'b1;
              end else begin
                mem_write <= 1'b1;
                cs_ram    <= 1'b1;
              end
            end else begin
              mem_read <= 1'b1;
              cs_rom   <= pick_is_rom;
              cs_ram   <= ~pick_is_rom;
            end
            state_reg <= ACCESS;
          end
        end

        ACCESS: begin
`ifdef BUS_ARB_RR_EN
          last_reg <= win_reg;
`endif
          if (we_reg == IO_WRITE) begin
            mem_write <= 1'b0;
            cs_rom    <= 1'b0;
            cs_ram    <= 1'b0;
            state_reg <= IDLE;
          end else if (RD_LATENCY == 0) begin
            m_rdata           <= mem_rdata;
            m_rvalid[win_reg] <= 1'b1;
            mem_read          <= 1'b0;
            cs_rom            <= 1'b0;
            cs_ram            <= 1'b0;
            state_reg         <= RESP;
          end else begin
            cnt_reg   <= 2'(RD_LATENCY - 1);
            state_reg <= WAIT;
          end
        end

        WAIT: begin
          if (cnt_reg == 2'd0) begin
            m_rdata           <= mem_rdata;
            m_rvalid[win_reg] <= 1'b1;
            mem_read          <= 1'b0;
            cs_rom            <= 1'b0;
            cs_ram            <= 1'b0;
            state_reg         <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 2'd1;
          end
        end

        RESP: begin
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: instance a uses RD_LATENCY=0, instance b
// uses RD_LATENCY=2 with a RAM model that answers two cycles after ACCESS.
module tb_bus_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  logic [1:0]  a_req = '0, a_we = '0;
  logic [31:0] a_addr = '0;
  logic [15:0] a_wdata = '0;
  logic [1:0]  a_gnt, a_rvalid;
  logic [7:0]  a_rdata, a_mem_wdata, a_mem_rdata;
  logic        a_ro_err, a_mem_read, a_mem_write, a_cs_rom, a_cs_ram;
  logic [15:0] a_mem_addr;

  logic [1:0]  b_req = '0, b_we = '0;
  logic [31:0] b_addr = '0;
  logic [15:0] b_wdata = '0;
  logic [1:0]  b_gnt, b_rvalid;
  logic [7:0]  b_rdata, b_mem_wdata, b_mem_rdata;
  logic        b_ro_err, b_mem_read, b_mem_write, b_cs_rom, b_cs_ram;
  logic [15:0] b_mem_addr;
  logic [1:0]  b_rd_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.RD_LATENCY(0)) dut_a (
    .clk(clk), .reset(reset), .m_req(a_req), .m_we(a_we), .m_addr(a_addr),
    .m_wdata(a_wdata), .m_gnt(a_gnt), .m_rvalid(a_rvalid), .m_rdata(a_rdata),
    .ro_err(a_ro_err), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .cs_rom(a_cs_rom),
    .cs_ram(a_cs_ram), .mem_rdata(a_mem_rdata)
  );

  bus_arbiter #(.RD_LATENCY(2)) dut_b (
    .clk(clk), .reset(reset), .m_req(b_req), .m_we(b_we), .m_addr(b_addr),
    .m_wdata(b_wdata), .m_gnt(b_gnt), .m_rvalid(b_rvalid), .m_rdata(b_rdata),
    .ro_err(b_ro_err), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .cs_rom(b_cs_rom),
    .cs_ram(b_cs_ram), .mem_rdata(b_mem_rdata)
  );

  // ROM byte = 0xE3 ^ addr[7:0] (0x0002 -> 0xE1); RAM byte = 0x5A ^ addr[7:0]
  assign a_mem_rdata = a_cs_rom ? (8'hE3 ^ a_mem_addr[7:0]) : (8'h5A ^ a_mem_addr[7:0]);

  // Slow RAM: data valid only on the second cycle after the read strobe starts
  always @(posedge clk) begin
    if (reset) b_rd_cnt <= 2'd0;
    else       b_rd_cnt <= b_mem_read ? b_rd_cnt + 2'd1 : 2'd0;
  end
  assign b_mem_rdata = (b_rd_cnt == 2'd2) ? 8'h3C : 8'h00;

  logic [40:0] a_outs, b_outs;
  assign a_outs = {a_gnt, a_rvalid, a_rdata, a_ro_err, a_mem_addr, a_mem_wdata,
                   a_mem_read, a_mem_write, a_cs_rom, a_cs_ram};
  assign b_outs = {b_gnt, b_rvalid, b_rdata, b_ro_err, b_mem_addr, b_mem_wdata,
                   b_mem_read, b_mem_write, b_cs_rom, b_cs_ram};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  logic [1:0] exp_gnt;

  initial begin
    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check("a_reset_outs", 64'(a_outs), 64'd0);
    check("b_reset_outs", 64'(b_outs), 64'd0);
    reset = 1'b0;
    tick();

    // m0 reads ROM 0x0002, zero latency
    a_req = 2'b01; a_we = 2'b00; a_addr = {16'h0000, 16'h0002};
    tick();
    check("rd_rom_gnt", 64'(a_gnt), 64'h1);
    check("rd_rom_cs", 64'({a_cs_rom, a_cs_ram, a_mem_read, a_mem_write}), 64'b1010);
    check("rd_rom_addr", 64'(a_mem_addr), 64'h0002);
    a_req = 2'b00;
    tick();
    check("rd_rom_rvalid", 64'(a_rvalid), 64'h1);
    check("rd_rom_rdata", 64'(a_rdata), 64'hE1);
    check("rd_rom_resp_strobes", 64'({a_mem_read, a_cs_rom, a_cs_ram, a_gnt}), 64'd0);
    tick();
    check("rd_rom_rvalid_gone", 64'(a_rvalid), 64'h0);
    check("rd_rom_rdata_hold", 64'(a_rdata), 64'hE1);

    // m1 writes 0xA5 to RAM 0x4010
    a_req = 2'b10; a_we = 2'b10; a_addr = {16'h4010, 16'h0000}; a_wdata = {8'hA5, 8'h00};
    tick();
    check("wr_ram_gnt", 64'(a_gnt), 64'h2);
    check("wr_ram_cs", 64'({a_cs_rom, a_cs_ram, a_mem_read, a_mem_write, a_ro_err}), 64'b01010);
    check("wr_ram_addr", 64'(a_mem_addr), 64'h4010);
    check("wr_ram_wdata", 64'(a_mem_wdata), 64'hA5);
    a_req = 2'b00;
    tick();
    check("wr_ram_idle", 64'({a_gnt, a_mem_write, a_cs_ram}), 64'd0);

    // m0 writes to ROM 0x0100: dropped, issued the cycle right after the write
    a_req = 2'b01; a_we = 2'b01; a_addr = {16'h0000, 16'h0100}; a_wdata = {8'h00, 8'h77};
    tick();
    check("wr_rom_gnt", 64'(a_gnt), 64'h1);
    check("wr_rom_err", 64'(a_ro_err), 64'h1);
    check("wr_rom_quiet", 64'({a_mem_write, a_mem_read, a_cs_rom, a_cs_ram}), 64'd0);
    a_req = 2'b00; a_we = 2'b00;
    tick();
    check("wr_rom_err_pulse", 64'({a_ro_err, a_gnt}), 64'd0);

    // RD_LATENCY=2 read of RAM 0x4000 on instance b
    b_req = 2'b01; b_we = 2'b00; b_addr = {16'h0000, 16'h4000};
    tick();
    check("lat2_gnt", 64'(b_gnt), 64'h1);
    check("lat2_access", 64'({b_mem_read, b_cs_rom, b_cs_ram}), 64'b101);
    b_req = 2'b00;
    tick();
    check("lat2_wait1", 64'({b_mem_read, b_cs_ram, b_rvalid}), 64'b1100);
    tick();
    check("lat2_wait2", 64'({b_mem_read, b_cs_ram, b_rvalid}), 64'b1100);
    tick();
    check("lat2_rvalid", 64'(b_rvalid), 64'h1);
    check("lat2_rdata", 64'(b_rdata), 64'h3C);
    check("lat2_resp_strobe", 64'({b_mem_read, b_cs_ram}), 64'd0);
    tick();

    // Reset while b is in WAIT: read abandoned, no rvalid
    b_req = 2'b10; b_we = 2'b00; b_addr = {16'h8000, 16'h0000};
    tick();
    check("rst_wait_gnt", 64'(b_gnt), 64'h2);
    b_req = 2'b00;
    tick();
    check("rst_wait_in_wait", 64'(b_mem_read), 64'h1);
    reset = 1'b1;
    tick();
    check("rst_wait_outs", 64'(b_outs), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("rst_wait_no_rvalid%0d", i), 64'(b_rvalid), 64'd0);
    end
    b_req = 2'b10; b_addr = {16'h4000, 16'h0000};
    tick();
    check("rst_after_gnt", 64'(b_gnt), 64'h2);
    b_req = 2'b00;
    tick();
    tick();
    tick();
    check("rst_after_rvalid", 64'(b_rvalid), 64'h2);
    check("rst_after_rdata", 64'(b_rdata), 64'h3C);

    // Contention: both masters read continuously (pointer fresh from reset)
    a_req = 2'b11; a_we = 2'b00; a_addr = {16'h4030, 16'h4020};
    for (int t = 0; t < 4; t++) begin
`ifdef BUS_ARB_RR_EN
      exp_gnt = (t % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_gnt = 2'b01;
`endif
      tick();
      check($sformatf("cont%0d_gnt", t), 64'(a_gnt), 64'(exp_gnt));
      tick();
      check($sformatf("cont%0d_rvalid", t), 64'(a_rvalid), 64'(exp_gnt));
      check($sformatf("cont%0d_rdata", t), 64'(a_rdata),
            (exp_gnt == 2'b01) ? 64'h7A : 64'h6A);
      tick();
    end
    a_req = 2'b00;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
